cci_mpf_csr_event_ctrs: RTL

- Parametrised event-counter bank behind the MPF CSR manager.
- Replaces the fixed set of single-bit shim event wires with N_EVENTS multi-count increment lanes. Each lane has a counter, a sticky overflow flag, an atomic snapshot, and a global clear.
- The CSR manager instantiates this block and reads the snapshotted counters over a one-cycle indexed read port, which services MMIO reads of event CSRs.

---
 rtl/cci_mpf_csrs_pkg.sv | 21 ++
 rtl/cci_mpf_evt_ctr_lane.sv | 55 +++++
 rtl/cci_mpf_csr_event_ctrs.sv | 78 +++++++
 3 files changed

// File: rtl/cci_mpf_csrs_pkg.sv
// Shared definitions for the MPF CSR manager and its event-counter bank.
package cci_mpf_csrs_pkg;

  localparam int CCI_MPF_EVT_RSP_OVF_BIT = 63;
  localparam int CCI_MPF_EVT_CTR_DFLT_W  = 48;

  typedef struct packed {
    logic                                          ovf;
    logic [CCI_MPF_EVT_RSP_OVF_BIT-CCI_MPF_EVT_CTR_DFLT_W-1:0] pad;
    logic [CCI_MPF_EVT_CTR_DFLT_W-1:0]             count;
  } t_cci_mpf_evt_ctr_rsp;

  // Builds a 64-bit event CSR word for any counter width: ovf on top, count zero-extended.
  function automatic logic [63:0] cci_mpf_evt_rsp_pack(input logic ovf, input logic [62:0] count);
    logic [63:0] r;
    r = {1'b0, count};
    r[CCI_MPF_EVT_RSP_OVF_BIT] = ovf;
    return r;
  endfunction

endpackage

// File: rtl/cci_mpf_evt_ctr_lane.sv
// One event-counter lane: live count + sticky overflow, with a snapshot shadow copy.
module cci_mpf_evt_ctr_lane #(
  parameter int INC_WIDTH = 2,
  parameter int CTR_WIDTH = 48,
  parameter int SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [INC_WIDTH-1:0] inc,
  input  logic                 clear,
  input  logic                 snapshot,
  output logic                 ovf,
  output logic [CTR_WIDTH-1:0] shadow_cnt,
  output logic                 shadow_ovf
);

  logic [CTR_WIDTH-1:0] cnt_q, cnt_d, shadow_q, shadow_d;
  logic                 ovf_q, ovf_d, sovf_q, sovf_d;
  logic [CTR_WIDTH:0]   sum;

  always_comb begin
    sum    = {1'b0, cnt_q} + {{(CTR_WIDTH+1-INC_WIDTH){1'b0}}, inc};
    cnt_d  = sum[CTR_WIDTH-1:0];
    ovf_d  = ovf_q;
    // Clear still adds this cycle's staged increment so no event is dropped.
    if (clear) begin
      cnt_d = {{(CTR_WIDTH-INC_WIDTH){1'b0}}, inc};
      ovf_d = 1'b0;
    end else if (sum[CTR_WIDTH]) begin
      ovf_d = 1'b1;
      if (SATURATE != 0) cnt_d = '1;
    end
    shadow_d = snapshot ? cnt_q : shadow_q;
    sovf_d   = snapshot ? ovf_q : sovf_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      shadow_q <= '0;
      sovf_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      shadow_q <= shadow_d;
      sovf_q   <= sovf_d;
    end
  end

  assign ovf        = ovf_q;
  assign shadow_cnt = shadow_q;
  assign shadow_ovf = sovf_q;

endmodule

// File: rtl/cci_mpf_csr_event_ctrs.sv
// Event-counter bank: staged increments, per-lane counters, indexed shadow read port.
module cci_mpf_csr_event_ctrs
  import cci_mpf_csrs_pkg::*;
#(
  parameter  int N_EVENTS  = 16,
  parameter  int INC_WIDTH = 2,
  parameter  int CTR_WIDTH = 48,
  parameter  int SATURATE  = 1,
  localparam int IDX_WIDTH = (N_EVENTS > 1) ? $clog2(N_EVENTS) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [N_EVENTS*INC_WIDTH-1:0] evt_inc,
  input  logic                          ctrl_snapshot,
  input  logic                          ctrl_clear,
  input  logic                          rd_valid,
  input  logic [IDX_WIDTH-1:0]          rd_idx,
  output logic                          rd_rsp_valid,
  output logic [63:0]                   rd_rsp_data,
  output logic                          ovf_any
);

  logic [N_EVENTS-1:0][INC_WIDTH-1:0] inc_q, inc_d;
  logic [N_EVENTS-1:0]                lane_ovf, lane_sovf;
  logic [N_EVENTS-1:0][CTR_WIDTH-1:0] lane_shadow;
  logic                               rsp_valid_q, rsp_valid_d;
  logic [63:0]                        rsp_data_q, rsp_data_d;
  logic                               ovf_any_q, ovf_any_d;

  for (genvar i = 0; i < N_EVENTS; i++) begin : g_lane
    cci_mpf_evt_ctr_lane #(
      .INC_WIDTH (INC_WIDTH),
      .CTR_WIDTH (CTR_WIDTH),
      .SATURATE  (SATURATE)
    ) u_lane (
      .clk        (clk),
      .reset_n    (reset_n),
      .inc        (inc_q[i]),
      .clear      (ctrl_clear),
      .snapshot   (ctrl_snapshot),
      .ovf        (lane_ovf[i]),
      .shadow_cnt (lane_shadow[i]),
      .shadow_ovf (lane_sovf[i])
    );
  end

  always_comb begin
    inc_d       = evt_inc;
    ovf_any_d   = |lane_ovf;
    rsp_valid_d = rd_valid;
    rsp_data_d  = rsp_data_q;
    // Reads see the shadow as registered, so a same-cycle snapshot is not visible.
    if (rd_valid) begin
      rsp_data_d = '0;
      if (32'(rd_idx) < N_EVENTS)
        rsp_data_d = cci_mpf_evt_rsp_pack(lane_sovf[rd_idx], 63'(lane_shadow[rd_idx]));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inc_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      ovf_any_q   <= 1'b0;
    end else begin
      inc_q       <= inc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      ovf_any_q   <= ovf_any_d;
    end
  end

  assign rd_rsp_valid = rsp_valid_q;
  assign rd_rsp_data  = rsp_data_q;
  assign ovf_any      = ovf_any_q;

endmodule
